// File: rtl/prio_encoder_8to3_q.sv
// Queued 8-to-3 priority encoder: latches request pulses into a pending register and serves them as codes over valid/ready.
// Optional merge-overflow flag (ovf_clr/ovf_out) is built in when PRIO_ENC_OVF_EN is defined.
module prio_encoder_8to3_q #(
  parameter int PRIO_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic       ready_in,
`ifdef PRIO_ENC_OVF_EN
  input  logic       ovf_clr,
  output logic       ovf_out,
`endif
  output logic [2:0] code_out,
  output logic       valid_out,
  output logic [7:0] pending_out,
  output logic       any_pending
);

  function automatic logic [2:0] enc_hi(input logic [7:0] p);
    logic [2:0] idx;
    casez (p)
      8'b1???_????: idx = 3'd7;
      8'b01??_????: idx = 3'd6;
      8'b001?_????: idx = 3'd5;
      8'b0001_????: idx = 3'd4;
      8'b0000_1???: idx = 3'd3;
      8'b0000_01??: idx = 3'd2;
      8'b0000_001?: idx = 3'd1;
      8'b0000_0001: idx = 3'd0;
      default:      idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] enc_lo(input logic [7:0] p);
    logic [2:0] idx;
    casez (p)
      8'b????_???1: idx = 3'd0;
      8'b????_??10: idx = 3'd1;
      8'b????_?100: idx = 3'd2;
      8'b????_1000: idx = 3'd3;
      8'b???1_0000: idx = 3'd4;
      8'b??10_0000: idx = 3'd5;
      8'b?100_0000: idx = 3'd6;
      8'b1000_0000: idx = 3'd7;
      default:      idx = 3'd0;
    endcase
    return idx;
  endfunction

  logic [7:0] pending_q, pending_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       any_q, any_d;
  logic       load_s;
  logic       has_s;
  logic [2:0] sel_idx_s;
  logic [7:0] load_mask_s;
`ifdef PRIO_ENC_OVF_EN
  logic       ovf_q, ovf_d;
`endif

  // Selection looks only at the registered pending set, never at req_in.
  always_comb begin
    load_s    = ~valid_q | ready_in;
    has_s     = (pending_q != 8'd0);
    sel_idx_s = (PRIO_HIGH != 0) ? enc_hi(pending_q) : enc_lo(pending_q);
    if (load_s && has_s) begin
      load_mask_s = 8'd1 << sel_idx_s;
    end else begin
      load_mask_s = 8'd0;
    end
  end

  // Next-state: a request on the bit being loaded re-pends it (set wins).
  always_comb begin
    pending_d = (pending_q & ~load_mask_s) | req_in;
    any_d     = (pending_d != 8'd0);
    code_d    = code_q;
    valid_d   = valid_q;
    if (load_s) begin
      valid_d = has_s;
      if (has_s) begin
        code_d = sel_idx_s;
      end else begin
        code_d = code_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

`ifdef PRIO_ENC_OVF_EN
  // Sticky merge flag; a new merge on the clearing edge keeps it set.
  always_comb begin
    if ((req_in & pending_q & ~load_mask_s) != 8'd0) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_out = ovf_q;
`endif

  // Pending set and output code register; reset drops any code in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 8'd0;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
      any_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      any_q     <= any_d;
    end
  end

  assign code_out    = code_q;
  assign valid_out   = valid_q;
  assign pending_out = pending_q;
  assign any_pending = any_q;

endmodule

// File: tb/tb_prio_encoder_8to3_q.sv
// Bench for prio_encoder_8to3_q: both priority orders side by side, directed tables/sequences plus random traffic against a reference model.
module tb_prio_encoder_8to3_q;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       ready;
  logic [2:0] code_h, code_l;
  logic       valid_h, valid_l;
  logic [7:0] pend_h, pend_l;
  logic       any_h, any_l;
`ifdef PRIO_ENC_OVF_EN
  logic       clr;
  logic       ovf_h, ovf_l;
`endif

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  prio_encoder_8to3_q #(.PRIO_HIGH(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .req_in(req), .ready_in(ready),
`ifdef PRIO_ENC_OVF_EN
    .ovf_clr(clr), .ovf_out(ovf_h),
`endif
    .code_out(code_h), .valid_out(valid_h), .pending_out(pend_h), .any_pending(any_h));

  prio_encoder_8to3_q #(.PRIO_HIGH(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .req_in(req), .ready_in(ready),
`ifdef PRIO_ENC_OVF_EN
    .ovf_clr(clr), .ovf_out(ovf_l),
`endif
    .code_out(code_l), .valid_out(valid_l), .pending_out(pend_l), .any_pending(any_l));

  // Reference model: index 0 = bit 7 highest, index 1 = bit 0 highest.
  logic [7:0] m_pend [2];
  logic [2:0] m_code [2];
  logic       m_valid [2];
  logic       m_ovf [2];

  function automatic logic [2:0] pick(input logic [7:0] p, input bit high);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = high ? 7 - k : k;
      if (p[j]) return 3'(j);
    end
    return 3'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 8'd0; m_code[i] = 3'd0; m_valid[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [7:0] mask;
      mask = 8'd0;
      if (!m_valid[i] || ready) begin
        if (m_pend[i] != 8'd0) begin
          m_code[i]  = pick(m_pend[i], i == 0);
          m_valid[i] = 1'b1;
          mask[m_code[i]] = 1'b1;
        end else begin
          m_valid[i] = 1'b0;
        end
      end
`ifdef PRIO_ENC_OVF_EN
      if ((req & m_pend[i] & ~mask) != 8'd0) m_ovf[i] = 1'b1;
      else if (clr) m_ovf[i] = 1'b0;
`endif
      m_pend[i] = (m_pend[i] & ~mask) | req;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("h_code",  {5'd0, code_h},  {5'd0, m_code[0]});
    chk("h_valid", {7'd0, valid_h}, {7'd0, m_valid[0]});
    chk("h_pend",  pend_h,          m_pend[0]);
    chk("h_any",   {7'd0, any_h},   {7'd0, (m_pend[0] != 8'd0)});
    chk("l_code",  {5'd0, code_l},  {5'd0, m_code[1]});
    chk("l_valid", {7'd0, valid_l}, {7'd0, m_valid[1]});
    chk("l_pend",  pend_l,          m_pend[1]);
    chk("l_any",   {7'd0, any_l},   {7'd0, (m_pend[1] != 8'd0)});
`ifdef PRIO_ENC_OVF_EN
    chk("h_ovf", {7'd0, ovf_h}, {7'd0, m_ovf[0]});
    chk("l_ovf", {7'd0, ovf_l}, {7'd0, m_ovf[1]});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic       valid;
    logic [2:0] code_h;
    logic [7:0] pend_h;
    logic [2:0] code_l;
    logic [7:0] pend_l;
  } vec_t;

  vec_t vt [8];

  initial begin
    // Single pulse on bit 4, then multi-hot 8'b1000_0101, ready held high.
    vt[0] = '{8'h10, 1'b1, 1'b0, 3'd0, 8'h10, 3'd0, 8'h10};
    vt[1] = '{8'h00, 1'b1, 1'b1, 3'd4, 8'h00, 3'd4, 8'h00};
    vt[2] = '{8'h00, 1'b1, 1'b0, 3'd4, 8'h00, 3'd4, 8'h00};
    vt[3] = '{8'h85, 1'b1, 1'b0, 3'd4, 8'h85, 3'd4, 8'h85};
    vt[4] = '{8'h00, 1'b1, 1'b1, 3'd7, 8'h05, 3'd0, 8'h84};
    vt[5] = '{8'h00, 1'b1, 1'b1, 3'd2, 8'h01, 3'd2, 8'h80};
    vt[6] = '{8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 3'd7, 8'h00};
    vt[7] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 3'd7, 8'h00};

    rst_n = 1'b0; req = 8'd0; ready = 1'b0;
`ifdef PRIO_ENC_OVF_EN
    clr = 1'b0;
`endif
    model_reset();
    #12;
    check_model();
    chk("rst_valid", {7'd0, valid_h}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      req = vt[v].req; ready = vt[v].ready;
      tick();
      chk($sformatf("vec%0d_valid_h", v), {7'd0, valid_h}, {7'd0, vt[v].valid});
      chk($sformatf("vec%0d_valid_l", v), {7'd0, valid_l}, {7'd0, vt[v].valid});
      chk($sformatf("vec%0d_code_h", v),  {5'd0, code_h},  {5'd0, vt[v].code_h});
      chk($sformatf("vec%0d_pend_h", v),  pend_h,          vt[v].pend_h);
      chk($sformatf("vec%0d_code_l", v),  {5'd0, code_l},  {5'd0, vt[v].code_l});
      chk($sformatf("vec%0d_pend_l", v),  pend_l,          vt[v].pend_l);
    end

    // Re-request on the same edge bit 6 is loaded: served twice.
    req = 8'h40; ready = 1'b1; tick();
    req = 8'h40; tick();
    chk("rereq_pend6", {7'd0, pend_h[6]}, 8'd1);
    chk("rereq_first", {4'd0, valid_h, code_h}, {4'd0, 1'b1, 3'd6});
    req = 8'h00; tick();
    chk("rereq_second", {4'd0, valid_h, code_h}, {4'd0, 1'b1, 3'd6});
    tick();
    chk("rereq_done", {7'd0, valid_h}, 8'd0);

    // Backpressure with pending 8'b0000_1010.
    req = 8'h0A; ready = 1'b0; tick();
    req = 8'h00; tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_code", {4'd0, valid_h, code_h}, {4'd0, 1'b1, 3'd3});
      chk("bp_hold_pend", pend_h, 8'h02);
    end
    ready = 1'b1; tick();
    chk("bp_release", {4'd0, valid_h, code_h}, {4'd0, 1'b1, 3'd1});
    tick();
    chk("bp_empty", {7'd0, valid_h}, 8'd0);

`ifdef PRIO_ENC_OVF_EN
    // Bit 3 re-requested while stuck pending behind a held code.
    ready = 1'b0;
    req = 8'h80; tick();
    req = 8'h00; tick();
    req = 8'h08; tick();
    chk("ovf_first_req", {7'd0, ovf_h}, 8'd0);
    req = 8'h00; tick();
    req = 8'h08; tick();
    chk("ovf_set", {7'd0, ovf_h}, 8'd1);
    req = 8'h00; tick();
    ready = 1'b1; tick();
    chk("ovf_code3", {4'd0, valid_h, code_h}, {4'd0, 1'b1, 3'd3});
    tick();
    chk("ovf_single", {7'd0, valid_h}, 8'd0);
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("ovf_clr", {7'd0, ovf_h}, 8'd0);
`endif

    // Async reset mid-drain.
    ready = 1'b0; req = 8'hFF; tick();
    req = 8'h00; tick();
    chk("pre_rst_valid", {7'd0, valid_h}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", {6'd0, valid_h, valid_l}, 8'd0);
    chk("arst_pend",  pend_h | pend_l, 8'd0);
    chk("arst_code",  {2'd0, code_h, code_l}, 8'd0);
`ifdef PRIO_ENC_OVF_EN
    chk("arst_ovf", {6'd0, ovf_h, ovf_l}, 8'd0);
`endif
    #2 rst_n = 1'b1;
    ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_idle", {6'd0, valid_h, valid_l}, 8'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      req   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ready = ($urandom_range(0, 3) != 0);
`ifdef PRIO_ENC_OVF_EN
      clr   = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/prio_encoder_8to3_q.md
Name: prio_encoder_8to3_q

Overview:
- Queued 8-to-3 priority encoder. It is the inverse of the team's 3-to-8 one-hot decoder: it maps a set request line back to its 3-bit index, where bit i maps to code i.
- Request pulses on eight lines are latched into a pending register.
- Pending requests are served one at a time as 3-bit codes over a valid/ready handshake.
- Sits between event sources (interrupt/flag lines) and a consumer that dispatches by index.

Parameters:
- PRIO_HIGH, 1: 1 = bit 7 has highest priority; 0 = bit 0 has highest priority.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  8  request lines, sampled every rising edge; pulse or level.
- ready_in  input  1  consumer accepts code_out this cycle.
- code_out  output  3  index of the served request; bit i maps to code i.
- valid_out  output  1  code_out holds an unaccepted code.
- pending_out  output  8  current pending register.
- any_pending  output  1  OR of pending_out.

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset: pending=0, code_out=0, valid_out=0 (plus ovf_out=0 when the optional feature is built in).
  - rst_n low clears all state immediately, without waiting for a clock edge.
  - A code in flight mid-operation is dropped; there is no partial drain.
- Pending update, per edge:
  - pending <= (pending & ~load_mask) | req_in.
  - load_mask is the one-hot of the bit selected for load this cycle, else 0.
  - Set wins: a req_in bit equal to the bit being loaded re-pends it.
- Load condition: load = ~valid_out | ready_in.
- On load with pending != 0:
  - code_out <= priority index of pending, per PRIO_HIGH.
  - valid_out <= 1.
  - The selected bit is cleared from pending, i.e. pending clears on load, not on accept.
- On load with pending == 0: valid_out <= 0; code_out holds its last value.
- Selection uses the registered pending only. A req_in bit never bypasses pending into the same cycle's load.
- Backpressure (valid_out=1, ready_in=0):
  - code_out and valid_out are held stable.
  - pending keeps accumulating new requests.
- Latency:
  - req_in sampled at edge k -> pending bit set after k -> code_out/valid_out after edge k+1 (2 cycles, idle case).
- Throughput: one code per cycle with ready_in=1.
- Duplicate request for a bit already pending:
  - Merged; no count is kept, so one service results.
  - The optional feature flags this case.
- Priority encode is purely combinational from pending; there is no starvation protection.
- any_pending = |pending. It excludes the code currently held in the output register.

Optional Feature:
- Macro: PRIO_ENC_OVF_EN.
- Defined:
  - Adds port ovf_clr input 1 and port ovf_out output 1.
  - ovf_out is set on any edge where (req_in & pending & ~load_mask) != 0, i.e. a request merged into an already-pending bit.
  - ovf_out is sticky until ovf_clr=1 at an edge; set wins over clear on the same edge.
  - ovf_out resets to 0.
- Undefined: neither port exists; merges are silent.

Test Plan:
- Single pulse: req_in=8'b0001_0000 for one cycle, ready_in=1 -> valid_out=1 and code_out=3'b100 two edges later for exactly one cycle; pending_out returns to 0.
- Multi-hot, PRIO_HIGH=1: req_in=8'b1000_0101 for one cycle, ready_in=1 -> codes 7, 2, 0 on consecutive cycles, then valid_out=0. With PRIO_HIGH=0 -> codes 0, 2, 7.
- Backpressure: pending=8'b0000_1010, ready_in=0 for 5 cycles -> code_out=3 held stable and pending_out=8'b0000_0010. Then ready_in=1 -> code 1 next cycle, then valid_out=0.
- Re-request on load: req_in[6]=1 on the same edge bit 6 is loaded -> pending_out[6]=1 afterward; code 6 is served twice.
- Async reset mid-drain: pending=8'hFF, valid_out=1, rst_n low between edges -> valid_out=0, pending_out=0, code_out=0 immediately. After release, no codes are emitted.
- PRIO_ENC_OVF_EN defined: req_in[3] pulsed twice while bit 3 is pending and ready_in=0 -> ovf_out=1 and only one code 3 is emitted. ovf_clr pulse -> ovf_out=0. Macro undefined -> build has no ovf ports.
